// File: rtl/arm_pkg.sv
// arm_pkg: shared register-number and hazard-controller state types.
package arm_pkg;
   localparam logic [3:0] PC_REG = 4'd15;
   typedef logic [$bits(PC_REG)-1:0] reg_t;
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline stage info in, stall/flush controls out.
interface pipe_hazard_ctrl_if;
   import arm_pkg::*;
   logic forward_en, use_rn_id, two_src_id;
   reg_t src1_id, src2_id, exe_dest, mem_dest;
   logic exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, mem_ready;
   logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic flush_if_id, flush_id_ex, bubble_mem_wb;
   modport master (
      output forward_en, use_rn_id, two_src_id, src1_id, src2_id, exe_dest, mem_dest,
      output exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, mem_ready,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      input  flush_if_id, flush_id_ex, bubble_mem_wb
   );
   modport slave (
      input  forward_en, use_rn_id, two_src_id, src1_id, src2_id, exe_dest, mem_dest,
      input  exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, mem_ready,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      output flush_if_id, flush_id_ex, bubble_mem_wb
   );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage source versus EX/MEM destination data-hazard compare.
module hazard_detect
   import arm_pkg::*;
(
   input  logic forward_en,
   input  logic use_rn_id,
   input  logic two_src_id,
   input  reg_t src1_id,
   input  reg_t src2_id,
   input  reg_t exe_dest,
   input  logic exe_wb_en,
   input  logic exe_mem_r_en,
   input  reg_t mem_dest,
   input  logic mem_wb_en,
   output logic hazard
);
   logic exe_hit, mem_hit;
   assign exe_hit = exe_wb_en & ((use_rn_id & (src1_id == exe_dest)) | (two_src_id & (src2_id == exe_dest)));
   assign mem_hit = mem_wb_en & ((use_rn_id & (src1_id == mem_dest)) | (two_src_id & (src2_id == mem_dest)));
   // with forwarding only a load in EX cannot be bypassed in time
   assign hazard = forward_en ? exe_hit & exe_mem_r_en : exe_hit | mem_hit;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush control with memory-wait timeout and perf counters.
module pipe_hazard_ctrl
   import arm_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   pipe_hazard_ctrl_if.slave hz,
   output logic             mem_timeout,
   output state_t           state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   localparam int WW = $clog2(TIMEOUT + 1);
   state_t state_nxt;
   logic [WW-1:0] wait_cnt, wait_cnt_nxt, wait_cnt_inc;
   logic hazard, mem_stall, err, hold, run_ok, flush_br, haz_stall;
   hazard_detect u_hazard_detect (
      .forward_en  (hz.forward_en),
      .use_rn_id   (hz.use_rn_id),
      .two_src_id  (hz.two_src_id),
      .src1_id     (hz.src1_id),
      .src2_id     (hz.src2_id),
      .exe_dest    (hz.exe_dest),
      .exe_wb_en   (hz.exe_wb_en),
      .exe_mem_r_en(hz.exe_mem_r_en),
      .mem_dest    (hz.mem_dest),
      .mem_wb_en   (hz.mem_wb_en),
      .hazard      (hazard)
   );
   assign mem_stall = hz.mem_req & ~hz.mem_ready;
   assign err = state == ERROR;
   assign mem_timeout = err;
   assign wait_cnt_inc = wait_cnt + 1'b1;
   always_comb begin
      state_nxt = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN: begin
            state_nxt = mem_stall ? MEM_WAIT : RUN;
            wait_cnt_nxt = mem_stall ? '0 : wait_cnt;
         end
         MEM_WAIT: begin
            wait_cnt_nxt = mem_stall ? wait_cnt_inc : wait_cnt;
            state_nxt = !mem_stall ? RUN : (wait_cnt_inc == WW'(TIMEOUT - 1)) ? ERROR : MEM_WAIT;
         end
         default: state_nxt = ERROR;
      endcase
      // everything is forced quiet while reset is held
      hold = ~rst & (err | mem_stall);
      run_ok = ~rst & ~err & ~mem_stall;
      flush_br = run_ok & hz.branch_taken;
      haz_stall = run_ok & ~hz.branch_taken & hazard;
      hz.stall_pc = hold | haz_stall;
      hz.stall_if_id = hold | haz_stall;
      hz.stall_id_ex = hold;
      hz.stall_ex_mem = hold;
      hz.flush_if_id = flush_br;
      hz.flush_id_ex = flush_br | haz_stall;
      hz.bubble_mem_wb = hold;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         wait_cnt <= '0;
         stall_cycles <= '0;
         flush_count <= '0;
      end else begin
         state <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (hz.stall_pc && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
         if (flush_br && !(&flush_count)) flush_count <= flush_count + 1'b1;
      end
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, memory-wait cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port forward_en  in  1  forwarding unit active.
REQ-006 SHALL have ports src1_id, src2_id  in  4 each  ID-stage source register numbers.
REQ-007 SHALL have ports use_rn_id, two_src_id  in  1 each  ID instruction reads src1 / reads src2.
REQ-008 SHALL have ports exe_dest  in  4, exe_wb_en  in  1, exe_mem_r_en  in  1  EX-stage destination, writeback enable and load flag.
REQ-009 SHALL have ports mem_dest  in  4, mem_wb_en  in  1  MEM-stage destination and writeback enable.
REQ-010 SHALL have port branch_taken  in  1  EX-stage branch resolved taken.
REQ-011 SHALL have ports mem_req  in  1, mem_ready  in  1  MEM-stage access request and data-memory completion.
REQ-012 SHALL have ports stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the register.
REQ-013 SHALL have ports flush_if_id, flush_id_ex, bubble_mem_wb  out  1 each  load zeros (NOP) into the register.
REQ-014 SHALL have ports mem_timeout  out  1 (sticky error), state  out  2, stall_cycles and flush_count  out  CNT_W each.

Function
REQ-015 SHALL define the hazard for forward_en=0 as src1 matching an active EX or MEM destination (use_rn_id=1), or src2 matching one (two_src_id=1); a destination is active when its wb_en=1.
REQ-016 SHALL define the hazard for forward_en=1 as exe_mem_r_en=1, exe_wb_en=1 and an active src1/src2 matching exe_dest; MEM-stage matches are ignored.
REQ-017 SHALL define mem_stall = mem_req & ~mem_ready; all control outputs are combinational from state and the current inputs.
REQ-018 SHALL apply priority error > mem_stall > branch_taken > hazard within a cycle.
REQ-019 SHALL on mem_stall assert all four stall_* and bubble_mem_wb, and deassert both flushes; the branch or hazard is re-evaluated once the stall ends.
REQ-020 SHALL on branch_taken without mem_stall assert flush_if_id and flush_id_ex for exactly that cycle, with no stall; any concurrent hazard is ignored.
REQ-021 SHALL on hazard without a higher-priority event assert stall_pc, stall_if_id and flush_id_ex (one bubble per cycle the hazard holds).
REQ-022 SHALL use FSM states RUN=0, MEM_WAIT=1, ERROR=2: RUN->MEM_WAIT on mem_stall; MEM_WAIT->RUN on cycle with mem_ready=1 or mem_req=0.
REQ-023 SHALL zero wait_cnt on entry to MEM_WAIT and increment it each MEM_WAIT cycle with mem_stall; when wait_cnt reaches TIMEOUT-1 with mem_stall still high, next state is ERROR.
REQ-024 SHALL in ERROR hold mem_timeout=1 and all stall_* =1 and flushes=0 until rst; ERROR is left only via reset.
REQ-025 SHALL increment stall_cycles each cycle stall_pc=1, and flush_count each cycle flush_id_ex=1 due to a branch; both saturate at all-ones.
REQ-026 SHALL treat register number 15 (PC) like any other register for matching.

Reset
REQ-027 SHALL on rst asynchronously force state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_count=0.
REQ-028 SHALL while rst=1 drive all stall_*, flush_* and bubble_mem_wb to 0; reset mid-MEM_WAIT abandons the wait without error.

Structure
REQ-029 SHALL place the state enum (RUN, MEM_WAIT, ERROR) and the PC register-number constant in the shared package arm_pkg.
REQ-030 SHALL implement the combinational source/destination compare as sub-module hazard_detect; the FSM, counters and priority logic stay in pipe_hazard_ctrl.

Verification
REQ-031 SHALL verify forward_en=0, src1_id=3, use_rn_id=1, mem_dest=3, mem_wb_en=1 -> stall_pc=1, flush_id_ex=1; same with forward_en=1 -> no stall.
REQ-032 SHALL verify forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src2_id=5, two_src_id=1 -> exactly 1 bubble cycle, then stall clears when EX changes.
REQ-033 SHALL verify branch_taken=1 with a concurrent hazard -> flush_if_id=flush_id_ex=1, stall_pc=0, flush_count +1.
REQ-034 SHALL verify mem_req=1, mem_ready low 4 cycles -> 4 cycles all stalls and state=MEM_WAIT, RUN after the mem_ready cycle, stall_cycles=4.
REQ-035 SHALL verify TIMEOUT=8 with mem_ready never asserted -> state=ERROR, mem_timeout=1 after 8 stalled cycles; rst then clears everything to 0.
REQ-036 SHALL verify stall_cycles with CNT_W=4 held stalled 20 cycles -> saturates at 15.
